// File: rtl/async_fifo_wptr_ctrl_if.sv
// Push handshake and memory write port of the async FIFO write-side
// controller.
interface async_fifo_wptr_ctrl_if #(
    parameter int p_addr_width = 3
);
    logic                    push_val;
    logic                    push_rdy;
    logic                    wen;
    logic [p_addr_width-1:0] waddr;

    modport master (
        output push_val,
        input  push_rdy,
        input  wen,
        input  waddr
    );

    modport slave (
        input  push_val,
        output push_rdy,
        output wen,
        output waddr
    );
endinterface

// File: rtl/async_fifo_wptr_ctrl.sv
// Async FIFO write-domain pointer/flag controller: binary and Gray write
// pointers, full/almost-full, pessimistic occupancy and sticky overflow.
module async_fifo_wptr_ctrl #(
    parameter int p_addr_width   = 3,
    parameter int p_afull_thresh = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    async_fifo_wptr_ctrl_if.slave push,
    output logic [p_addr_width:0] wptr_gray,
    input  logic [p_addr_width:0] rptr_gray_sync,
    output logic                  full,
    output logic                  almost_full,
    output logic [p_addr_width:0] count,
    input  logic                  clr_ovf,
    output logic                  overflow
);
    localparam int A = p_addr_width;
    // Full when the two top Gray bits differ and the rest match.
    localparam logic [A:0] c_full_mask = (A+1)'(3) << (A - 1);
    localparam logic [A:0] c_thresh    = (A+1)'(p_afull_thresh);

    function automatic logic [A:0] bin2gray(input logic [A:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [A:0] gray2bin(input logic [A:0] g);
        logic [A:0] b;
        b[A] = g[A];
        for (int i = A - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [A:0] wbin;
    logic [A:0] wbin_nxt;
    logic [A:0] wgray_nxt;
    logic [A:0] rbin;
    logic       fire;

    assign full          = (wptr_gray == (rptr_gray_sync ^ c_full_mask));
    assign push.push_rdy = ~full;
    // The memory is never written while the controller is in reset.
    assign fire          = push.push_val & ~full & ~reset;
    assign push.wen      = fire;
    assign push.waddr    = wbin[A-1:0];

    assign wbin_nxt    = wbin + (A+1)'(fire);
    assign wgray_nxt   = bin2gray(wbin_nxt);
    assign rbin        = gray2bin(rptr_gray_sync);
    assign count       = wbin - rbin;
    assign almost_full = (count >= c_thresh);

    always_ff @(posedge clk) begin
        if (reset) begin
            wbin      <= '0;
            wptr_gray <= '0;
        end else begin
            wbin      <= wbin_nxt;
            wptr_gray <= wgray_nxt;
        end
    end

    // Set dominates clear so a fresh overflow is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push.push_val & full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    a_gray_step: assert property (
        @(posedge clk) disable iff (reset)
        $countones(wgray_nxt ^ wptr_gray) <= 1
    );
endmodule

// File: tb/tb_async_fifo_wptr_ctrl.sv
// Directed bench for async_fifo_wptr_ctrl at depth 8, almost-full
// threshold 6.
module tb_async_fifo_wptr_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] wptr_gray;
    logic [3:0] rptr_gray_sync;
    logic       full;
    logic       almost_full;
    logic [3:0] count;
    logic       clr_ovf;
    logic       overflow;
    logic [3:0] rptr_prev = 4'd0;

    int checks = 0;
    int errors = 0;

    logic [3:0] gt [0:8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                             4'b0111, 4'b0101, 4'b0100, 4'b1100};

    async_fifo_wptr_ctrl_if #(.p_addr_width(3)) pif ();

    async_fifo_wptr_ctrl #(
        .p_addr_width  (3),
        .p_afull_thresh(6)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .push          (pif.slave),
        .wptr_gray     (wptr_gray),
        .rptr_gray_sync(rptr_gray_sync),
        .full          (full),
        .almost_full   (almost_full),
        .count         (count),
        .clr_ovf       (clr_ovf),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Input contract: synchronized read pointer steps at most one bit.
    always @(posedge clk) begin
        if (!reset) begin
            assert ($countones(rptr_gray_sync ^ rptr_prev) <= 1)
            else $error("rptr_gray_sync contract broken: %b -> %b",
                        rptr_prev, rptr_gray_sync);
        end
        rptr_prev <= rptr_gray_sync;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        pif.push_val   = 1'b0;
        clr_ovf        = 1'b0;
        rptr_gray_sync = 4'd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (wptr_gray !== 4'b0000) begin
            errors++;
            $display("FAIL reset_wptr: got %b want 0000", wptr_gray);
        end
        checks++;
        if (full !== 1'b0 || pif.push_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_full: full %b rdy %b want 0 1",
                     full, pif.push_rdy);
        end
        checks++;
        if (count !== 4'd0 || almost_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_count: count %0d af %b want 0 0",
                     count, almost_full);
        end
        checks++;
        if (pif.wen !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_wen_ovf: wen %b ovf %b want 0 0",
                     pif.wen, overflow);
        end
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 10; i++) begin
            pif.push_val = 1'b1;
            #1;
            checks++;
            if (pif.wen !== (i < 8)) begin
                errors++;
                $display("FAIL fill_wen cyc %0d: got %b want %b",
                         i, pif.wen, (i < 8));
            end
            if (i < 8) begin
                checks++;
                if (pif.waddr !== 3'(i) || count !== 4'(i)) begin
                    errors++;
                    $display("FAIL fill_addr cyc %0d: waddr %0d count %0d want %0d",
                             i, pif.waddr, count, i);
                end
                checks++;
                if (almost_full !== (i >= 6) || wptr_gray !== gt[i]) begin
                    errors++;
                    $display("FAIL fill_af cyc %0d: af %b gray %b want %b %b",
                             i, almost_full, wptr_gray, (i >= 6), gt[i]);
                end
            end else begin
                checks++;
                if (full !== 1'b1 || pif.push_rdy !== 1'b0 ||
                    count !== 4'd8 || wptr_gray !== 4'b1100) begin
                    errors++;
                    $display("FAIL fill_full cyc %0d: full %b rdy %b count %0d gray %b want 1 0 8 1100",
                             i, full, pif.push_rdy, count, wptr_gray);
                end
            end
            tick();
        end
        pif.push_val = 1'b0;
        #1;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL fill_ovf: got %b want 1", overflow);
        end
        tick();
    endtask

    task automatic test_drain();
        rptr_gray_sync = 4'b0001;
        #1;
        checks++;
        if (full !== 1'b0 || pif.push_rdy !== 1'b1 || count !== 4'd7) begin
            errors++;
            $display("FAIL drain_1: full %b rdy %b count %0d want 0 1 7",
                     full, pif.push_rdy, count);
        end
        tick();
        rptr_gray_sync = 4'b0011;
        #1;
        checks++;
        if (count !== 4'd6 || almost_full !== 1'b1) begin
            errors++;
            $display("FAIL drain_2: count %0d af %b want 6 1",
                     count, almost_full);
        end
        tick();
        pif.push_val = 1'b1;
        #1;
        checks++;
        if (pif.wen !== 1'b1 || pif.waddr !== 3'd0) begin
            errors++;
            $display("FAIL drain_push: wen %b waddr %0d want 1 0",
                     pif.wen, pif.waddr);
        end
        tick();
        pif.push_val = 1'b0;
        #1;
        checks++;
        if (wptr_gray !== 4'b1101 || count !== 4'd7) begin
            errors++;
            $display("FAIL drain_gray: gray %b count %0d want 1101 7",
                     wptr_gray, count);
        end
        tick();
    endtask

    task automatic test_overflow_clear();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        #1;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want 0", overflow);
        end
        pif.push_val = 1'b1;
        #1;
        checks++;
        if (pif.wen !== 1'b1 || pif.waddr !== 3'd1) begin
            errors++;
            $display("FAIL ovf_push: wen %b waddr %0d want 1 1",
                     pif.wen, pif.waddr);
        end
        tick();
        clr_ovf = 1'b1;
        #1;
        checks++;
        if (full !== 1'b1 || pif.wen !== 1'b0 || count !== 4'd8) begin
            errors++;
            $display("FAIL ovf_full: full %b wen %b count %0d want 1 0 8",
                     full, pif.wen, count);
        end
        tick();
        clr_ovf      = 1'b0;
        pif.push_val = 1'b0;
        #1;
        checks++;
        if (overflow !== 1'b1 || wptr_gray !== 4'b1111) begin
            errors++;
            $display("FAIL ovf_set_wins: ovf %b gray %b want 1 1111",
                     overflow, wptr_gray);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        #1;
        checks++;
        if (overflow !== 1'b0 || wptr_gray !== 4'b0000 || count !== 4'd0) begin
            errors++;
            $display("FAIL rst_clean: ovf %b gray %b count %0d want 0 0000 0",
                     overflow, wptr_gray, count);
        end
        for (int k = 0; k < 5; k++) begin
            pif.push_val = 1'b1;
            #1;
            checks++;
            if (pif.wen !== 1'b1 || pif.waddr !== 3'(k)) begin
                errors++;
                $display("FAIL rst_burst %0d: wen %b waddr %0d want 1 %0d",
                         k, pif.wen, pif.waddr, k);
            end
            tick();
        end
        checks++;
        if (wptr_gray !== 4'b0111) begin
            errors++;
            $display("FAIL rst_pre: gray %b want 0111", wptr_gray);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (pif.wen !== 1'b0) begin
            errors++;
            $display("FAIL rst_wen: got %b want 0", pif.wen);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (wptr_gray !== 4'b0000 || overflow !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL rst_after: gray %b ovf %b count %0d want 0000 0 0",
                     wptr_gray, overflow, count);
        end
        checks++;
        if (pif.wen !== 1'b1 || pif.waddr !== 3'd0) begin
            errors++;
            $display("FAIL rst_resume0: wen %b waddr %0d want 1 0",
                     pif.wen, pif.waddr);
        end
        tick();
        #1;
        checks++;
        if (pif.waddr !== 3'd1 || wptr_gray !== 4'b0001) begin
            errors++;
            $display("FAIL rst_resume1: waddr %0d gray %b want 1 0001",
                     pif.waddr, wptr_gray);
        end
        tick();
        pif.push_val = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        logic [3:0] b;
        logic [3:0] nb;
        logic [3:0] rb;
        logic [3:0] prevg;
        logic [3:0] expg;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            b  = 4'(k);
            rb = b - 4'd2;
            rptr_gray_sync = (k >= 2) ? (rb ^ (rb >> 1)) : 4'd0;
            pif.push_val = 1'b1;
            #1;
            checks++;
            if (pif.wen !== 1'b1 || pif.waddr !== b[2:0] || full !== 1'b0) begin
                errors++;
                $display("FAIL wrap_push %0d: wen %b waddr %0d full %b want 1 %0d 0",
                         k, pif.wen, pif.waddr, full, b[2:0]);
            end
            checks++;
            if (count !== ((k < 2) ? b : 4'd2)) begin
                errors++;
                $display("FAIL wrap_count %0d: got %0d want %0d",
                         k, count, (k < 2) ? b : 4'd2);
            end
            prevg = wptr_gray;
            tick();
            nb   = b + 4'd1;
            expg = nb ^ (nb >> 1);
            checks++;
            if ($countones(wptr_gray ^ prevg) != 1 || wptr_gray !== expg) begin
                errors++;
                $display("FAIL wrap_gray %0d: %b -> %b want -> %b",
                         k, prevg, wptr_gray, expg);
            end
            if (k == 15) begin
                checks++;
                if (prevg !== 4'b1000 || wptr_gray !== 4'b0000) begin
                    errors++;
                    $display("FAIL wrap_15: %b -> %b want 1000 -> 0000",
                             prevg, wptr_gray);
                end
            end
        end
        pif.push_val = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        int  n;
        bit  pv;
        bit  ovf_exp;
        n       = 0;
        ovf_exp = 1'b0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            pv = ($urandom_range(0, 3) != 0);
            pif.push_val = pv;
            #1;
            checks++;
            if (pif.wen !== (pv && n < 8) || count !== 4'(n) ||
                full !== (n == 8)) begin
                errors++;
                $display("FAIL stall %0d: wen %b count %0d full %b want %b %0d %b",
                         c, pif.wen, count, full, (pv && n < 8), n, (n == 8));
            end
            if (pv && n == 8) ovf_exp = 1'b1;
            if (pv && n < 8) n++;
            tick();
        end
        pif.push_val = 1'b0;
        #1;
        checks++;
        if (overflow !== ovf_exp) begin
            errors++;
            $display("FAIL stall_ovf: got %b want %b", overflow, ovf_exp);
        end
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        pif.push_val   = 1'b0;
        clr_ovf        = 1'b0;
        rptr_gray_sync = 4'd0;
        test_reset();
        test_fill();
        test_drain();
        test_overflow_clear();
        test_reset_mid();
        test_wrap();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/async_fifo_wptr_ctrl.md
Name: async_fifo_wptr_ctrl

Overview:
- Write-domain pointer and flag controller for the async FIFO.
- Directly upstream of the write-to-read pointer synchronizer: produces the registered Gray write pointer that synchronizer carries into the read domain.
- Consumes the Gray read pointer that the opposite synchronizer has already brought into this domain.
- Generates the memory write strobe and address, full and almost-full flags, a pessimistic occupancy count, and a sticky overflow flag.

Parameters:
- p_addr_width, 3, FIFO address width; depth = 2**p_addr_width.
- p_afull_thresh, 6, occupancy at or above which almost_full asserts; legal range 1..depth.

Ports:
- clk  input  1  write-domain clock
- reset  input  1  synchronous, active-high reset
- push_val  input  1  producer has a word to write
- push_rdy  output  1  controller can accept a word
- wen  output  1  memory write enable
- waddr  output  p_addr_width  memory write address
- wptr_gray  output  p_addr_width+1  registered Gray write pointer, to the synchronizer
- rptr_gray_sync  input  p_addr_width+1  synchronized Gray read pointer
- full  output  1  FIFO full as seen from the write side
- almost_full  output  1  count >= p_afull_thresh
- count  output  p_addr_width+1  write-side occupancy, 0..depth
- clr_ovf  input  1  clears the overflow flag
- overflow  output  1  sticky: push attempted while full

Behaviour:
- Reset and clocking:
  - Clock is clk; reset is synchronous, active-high.
  - On reset: wbin=0, wptr_gray=0, overflow=0.
  - Combinational outputs follow from these register values and rptr_gray_sync. With rptr_gray_sync=0 after reset: full=0, push_rdy=1, count=0, almost_full=0, wen=0.
- State:
  - wbin: (p_addr_width+1)-bit binary write pointer; the extra MSB is the wrap bit.
  - wptr_gray: separate register loaded with bin2gray of the next binary pointer. It is driven straight from a flop with no combinational logic on the output, so the synchronizer never samples glitches.
- Full detection (combinational):
  - full = (wptr_gray == {~rptr_gray_sync[A:A-1], rptr_gray_sync[A-2:0]}), where A = p_addr_width.
  - For p_addr_width=1 the compare is wptr_gray == ~rptr_gray_sync.
- Handshake:
  - push_rdy = ~full; fire = push_val & push_rdy.
  - wen = fire, same cycle; waddr = wbin[A-1:0], same cycle.
  - On fire: wbin <= wbin+1 and wptr_gray <= bin2gray(wbin+1). The write becomes visible to the read domain 1 cycle later through wptr_gray, plus the synchronizer latency.
  - No fire: both pointers hold.
  - push_val may drop without a handshake. Nothing is buffered inside the block.
- Wrap-around:
  - wbin wraps 2*depth-1 -> 0 modulo 2**(A+1).
  - Gray wrap is a single-bit change, e.g. for A=3: 1000 -> 0000.
  - wptr_gray changes by at most one bit per cycle. This is a required assertion.
- Occupancy:
  - rbin = gray2bin(rptr_gray_sync); count = (wbin - rbin) mod 2**(A+1).
  - count is pessimistic, because the read pointer is stale by the synchronizer latency. It never under-reports space used.
  - Always count <= depth; count == depth iff full.
  - almost_full = (count >= p_afull_thresh).
  - Read-pointer changes affect full, count and almost_full combinationally in the same cycle.
- Overflow:
  - overflow sets on push_val & full and stays set until clr_ovf.
  - If clr_ovf and a new overflow event occur in the same cycle, set wins.
  - No write happens on an overflow attempt.
- Reset mid-operation:
  - All state returns to reset values next edge, regardless of push_val.
  - The read side must be reset in the same window; this is a system requirement, not checked here.
- Input contract:
  - rptr_gray_sync changes at most one bit per write clock and only moves forward.
  - Behaviour for non-Gray input is undefined; the bench asserts the contract.

Test Plan:
- Reset, then fill (A=3, thresh 6): rptr_gray_sync=0000, push_val=1 for 10 cycles.
  - wen high for exactly 8 cycles, waddr 0..7.
  - almost_full asserts when count=6.
  - full=1, push_rdy=0 with count=8 and wptr_gray=1100.
  - Cycles 9 and 10 give no wen; overflow=1.
- Drain while full: rptr_gray_sync stepped 0000 -> 0001 -> 0011.
  - full drops in the same cycle; count goes 8 -> 7 -> 6.
  - A single push then gives wen=1 with waddr=0, and wptr_gray goes 1100 -> 1101.
- Wrap: 20 push/drain pairs with the read pointer trailing by 2.
  - wptr_gray changes exactly one bit per push and passes 1000 -> 0000.
  - waddr cycles 0..7 twice+; full is never asserted.
- Overflow clear: assert clr_ovf with push_val=0 -> overflow=0 next cycle.
  - While full, assert clr_ovf and push_val together -> overflow stays 1.
- Reset mid-burst: after 5 pushes, assert reset for one cycle with push_val=1.
  - Next cycle wbin=0, wptr_gray=0000, overflow=0, no wen during the reset cycle.
  - Pushes then resume at waddr=0.
- Stall pattern: random push_val with rptr held.
  - wen only when push_val & ~full; count equals the number of fired pushes, capped at 8.
